// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel produces a registered square
// wave plus a period-start tick; divisor updates are shadowed and applied at period wrap.
module clk_div_ch #(
    parameter int DIV_W   = 31,
    parameter int DEF_DIV = 20000000
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);
    logic [DIV_W-1:0] d_q, s_q, cnt_q;
    logic [DIV_W-1:0] d_nxt, s_nxt, cnt_nxt, apply_div;
    logic             run_q, run_nxt, pend_nxt, wrap;
    logic [DIV_W:0]   half;

    always_comb begin
        apply_div = pend ? s_q : d_q;
        s_nxt     = wr ? cfg_div : s_q;
        wrap      = (cnt_q == d_q - DIV_W'(1));
        d_nxt     = d_q;
        pend_nxt  = pend;
        cnt_nxt   = '0;
        run_nxt   = 1'b0;
        if (sync) begin
            // a write landing with sync bypasses the shadow entirely
            d_nxt    = wr ? cfg_div : apply_div;
            pend_nxt = 1'b0;
            run_nxt  = en && (d_nxt != '0);
        end else if (!en || !run_q) begin
            // idle channel: nothing to protect, take the shadow now; a write this edge stays pending
            d_nxt    = apply_div;
            pend_nxt = wr;
            run_nxt  = en && (d_nxt != '0);
        end else begin
            d_nxt    = wrap ? apply_div : d_q;
            pend_nxt = wr || (pend && !wrap);
            cnt_nxt  = wrap ? '0 : cnt_q + DIV_W'(1);
            run_nxt  = (d_nxt != '0);
        end
        if (!run_nxt) cnt_nxt = '0;
        half = ({1'b0, d_nxt} + (DIV_W+1)'(1)) >> 1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            d_q     <= DIV_W'(DEF_DIV);
            s_q     <= DIV_W'(DEF_DIV);
            cnt_q   <= '0;
            run_q   <= 1'b0;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            d_q     <= d_nxt;
            s_q     <= s_nxt;
            cnt_q   <= cnt_nxt;
            run_q   <= run_nxt;
            pend    <= pend_nxt;
            clk_out <= run_nxt && ({1'b0, cnt_nxt} < half);
            tick    <= run_nxt && (cnt_nxt == '0);
        end
    end
endmodule

module clk_div_multi #(
    parameter int CH      = 4,
    parameter int DIV_W   = 31,
    parameter int DEF_DIV = 20000000,
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [CH-1:0]    pend,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);
    // out-of-range cfg_ch decodes to no channel, so such writes vanish
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CW'(i));
        clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
            .clk_100MHz (clk_100MHz),
            .rst_n      (rst_n),
            .en         (en[i]),
            .sync       (sync),
            .wr         (wr),
            .cfg_div    (cfg_div),
            .pend       (pend[i]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i])
        );
    end
endmodule
